// File: rtl/iq_linear_interpolator_pkg.sv
// Shared constants, FSM encoding and helpers for the IQ linear interpolator.
package iq_interp_pkg;

  localparam logic MODE_HOLD   = 1'b0;
  localparam logic MODE_LINEAR = 1'b1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Ceiling log2, used to size the phase counter from L.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/iq_linear_interpolator_lane.sv
// One interpolation lane: keeps the previous/current input samples and
// registers the k-th output between them (hold or linear).
module iq_interp_lane
  import iq_interp_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int LOG2_L = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load,
  input  logic                     advance,
  input  logic                     mode_sel,
  input  logic [LOG2_L-1:0]        k,
  input  logic signed [WIDTH-1:0]  data,
  output logic signed [WIDTH-1:0]  sample
);

  localparam int PW = WIDTH + 1 + LOG2_L;

  logic signed [WIDTH-1:0] prev;
  logic signed [WIDTH-1:0] cur;
  logic signed [WIDTH-1:0] seg_a;
  logic signed [WIDTH-1:0] seg_b;
  logic signed [WIDTH-1:0] sample_nxt;
  logic signed [PW-1:0]    a_ext;
  logic signed [PW-1:0]    b_ext;
  logic signed [PW-1:0]    diff;
  logic signed [PW-1:0]    k_ext;
  logic signed [PW-1:0]    prod;
  logic signed [PW-1:0]    step;

  // Next output: on a load the segment is (cur -> new data) so the k=0 point
  // is produced the same edge the sample is captured.
  always_comb begin
    seg_a      = load ? cur  : prev;
    seg_b      = load ? data : cur;
    a_ext      = {{(LOG2_L + 1){seg_a[WIDTH-1]}}, seg_a};
    b_ext      = {{(LOG2_L + 1){seg_b[WIDTH-1]}}, seg_b};
    diff       = b_ext - a_ext;
    k_ext      = {{(WIDTH + 1){1'b0}}, k};
    prod       = diff * k_ext;
    step       = prod >>> LOG2_L;
    sample_nxt = (mode_sel == MODE_LINEAR) ? WIDTH'(a_ext + step) : seg_b;
  end

  // Sample history and output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev   <= '0;
      cur    <= '0;
      sample <= '0;
    end else begin
      if (load) begin
        prev <= cur;
        cur  <= data;
      end
      if (load || advance) begin
        sample <= sample_nxt;
      end
    end
  end

endmodule

// File: rtl/iq_linear_interpolator.sv
// IQ upsampler by L = 2**LOG2_L with zero-order-hold or linear smoothing.
//
//  state   | meaning
//  --------+------------------------------------------------------------
//  IDLE    | no burst in progress, ready for a new I/Q pair
//  RUN     | emitting outputs k = phase of the current pair
module iq_linear_interpolator
  import iq_interp_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int LOG2_L = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [WIDTH-1:0]  I_tdata,
  input  logic signed [WIDTH-1:0]  Q_tdata,
  input  logic                     in_tvalid,
  output logic                     in_tready,
  input  logic                     mode,
  output logic signed [WIDTH-1:0]  I_up,
  output logic signed [WIDTH-1:0]  Q_up,
  output logic                     vld,
  output logic                     overrun
);

  localparam int L       = 1 << LOG2_L;
  localparam int PHASE_W = clog2(L);
  localparam logic [PHASE_W-1:0] P_LAST = PHASE_W'(L - 1);

  state_t               state;
  state_t               state_nxt;
  logic [PHASE_W-1:0]   phase;
  logic [PHASE_W-1:0]   k_sel;
  logic                 mode_q;
  logic                 mode_sel;
  logic                 accept;
  logic                 advance;

  // State, phase, latched mode and the shared vld/overrun flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      phase   <= '0;
      mode_q  <= MODE_HOLD;
      vld     <= 1'b0;
      overrun <= 1'b0;
    end else begin
      state   <= state_nxt;
      phase   <= k_sel;
      vld     <= accept | advance;
      overrun <= in_tvalid & ~in_tready;
      if (accept) begin
        mode_q <= mode;
      end
    end
  end

  // Next-state: a burst ends at the last phase unless a new pair is accepted.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept) state_nxt = ST_RUN;
      ST_RUN:  if ((phase == P_LAST) && !accept) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Handshake and lane control, derived from registers and the input valid.
  always_comb begin
    in_tready = (state == ST_IDLE) || (phase == P_LAST);
    accept    = in_tvalid && in_tready;
    advance   = (state == ST_RUN) && (phase != P_LAST) && !accept;
    mode_sel  = accept ? mode : mode_q;
    k_sel     = phase;
    if (accept) begin
      k_sel = '0;
    end else if (advance) begin
      k_sel = phase + 1'b1;
    end
  end

  iq_interp_lane #(.WIDTH(WIDTH), .LOG2_L(LOG2_L)) u_lane_i (
    .clk      (clk),
    .rst      (rst),
    .load     (accept),
    .advance  (advance),
    .mode_sel (mode_sel),
    .k        (k_sel),
    .data     (I_tdata),
    .sample   (I_up)
  );

  iq_interp_lane #(.WIDTH(WIDTH), .LOG2_L(LOG2_L)) u_lane_q (
    .clk      (clk),
    .rst      (rst),
    .load     (accept),
    .advance  (advance),
    .mode_sel (mode_sel),
    .k        (k_sel),
    .data     (Q_tdata),
    .sample   (Q_up)
  );

endmodule
